// File: rtl/demux_1to4_16bit_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_1to4_16bit_reg_pkg
// Description : Shared constants and the select decoder for the 1-to-4 demux.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_1to4_16bit_reg_pkg;

  localparam int WIDTH = 16;
  localparam int NCH   = 4;

  localparam logic [1:0] CH0      = 2'd0;
  localparam logic [1:0] CH1      = 2'd1;
  localparam logic [1:0] CH2      = 2'd2;
  localparam logic [1:0] CH3      = 2'd3;
  localparam logic [1:0] RR_RESET = 2'd0;

  function automatic logic [NCH-1:0] sel_onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage : demux_1to4_16bit_reg_pkg
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
// Module      : demux_slot
// Description : One-entry output holding slot with valid/ready drain.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_slot
  import demux_1to4_16bit_reg_pkg::*;
#(
  parameter int DW = WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] d,
  input  logic          out_ready,
  output logic [DW-1:0] q,
  output logic          valid
);

  logic [DW-1:0] r_q;
  logic          r_valid;

  // A load wins over a drain, so a word can pass through every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q     <= '0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_q     <= d;
      r_valid <= 1'b1;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign q     = r_q;
  assign valid = r_valid;

endmodule : demux_slot
`default_nettype wire

// File: rtl/demux_1to4_16bit_reg.sv
`default_nettype none
// ============================================================================
// Module      : demux_1to4_16bit_reg
// Description : Registered 1-to-4 16-bit demux, explicit or round-robin routing.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1to4_16bit_reg
  import demux_1to4_16bit_reg_pkg::*;
#(
  parameter int DW  = WIDTH,
  parameter int NC  = NCH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    S,
  input  logic          rr_en,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data0,
  output logic [DW-1:0] out_data1,
  output logic [DW-1:0] out_data2,
  output logic [DW-1:0] out_data3,
  output logic [NC-1:0] out_valid,
  input  logic [NC-1:0] out_ready,
  output logic [1:0]    rr_ptr
);

  logic [1:0]    r_rr_ptr;
  logic [1:0]    w_sel;
  logic [NC-1:0] w_onehot;
  logic          w_accept;
  logic [DW-1:0] w_q [NC];
  logic [NC-1:0] w_valid;

  assign w_sel    = rr_en ? r_rr_ptr : S;
  assign w_onehot = sel_onehot(w_sel);

  // The selected slot may accept when empty or when it is draining this cycle.
  assign in_ready = rst_n & (~w_valid[w_sel] | out_ready[w_sel]);
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr <= RR_RESET;
    end else if (w_accept && rr_en) begin
      r_rr_ptr <= r_rr_ptr + 2'd1;
    end
  end

  generate
    for (genvar k = 0; k < NC; k++) begin : g_slot
      demux_slot #(.DW(DW)) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_accept & w_onehot[k]),
        .d         (in_data),
        .out_ready (out_ready[k]),
        .q         (w_q[k]),
        .valid     (w_valid[k])
      );
    end
  endgenerate

  assign out_data0 = w_q[CH0];
  assign out_data1 = w_q[CH1];
  assign out_data2 = w_q[CH2];
  assign out_data3 = w_q[CH3];
  assign out_valid = w_valid;
  assign rr_ptr    = r_rr_ptr;

endmodule : demux_1to4_16bit_reg
`default_nettype wire

// File: tb/tb_demux_1to4_16bit_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_1to4_16bit_reg
// Description : Self-checking bench for the registered 1-to-4 demux.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1to4_16bit_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  S;
  logic        rr_en;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [1:0]  rr_ptr;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_ptr;

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  demux_1to4_16bit_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .S         (S),
    .rr_en     (rr_en),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rr_ptr    (rr_ptr)
  );

  function automatic logic [15:0] obs_data(input logic [1:0] ch);
    case (ch)
      2'd0:    return out_data0;
      2'd1:    return out_data1;
      2'd2:    return out_data2;
      default: return out_data3;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b1; in_data = 16'hDEAD; S = 2'd1;
    rr_en = 1'b0; out_ready = 4'b0000;
    tick; tick;
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++; $display("FAIL reset_valid got %b exp %b", out_valid, 4'b0000);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_data(2'(k)) !== 16'h0000) begin
        errors++; $display("FAIL reset_data%0d got %h exp %h", k, obs_data(2'(k)), 16'h0000);
      end
    end
    checks++;
    if (rr_ptr !== 2'd0) begin
      errors++; $display("FAIL reset_ptr got %0d exp %0d", rr_ptr, 0);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready got %b exp %b", in_ready, 1'b0);
    end
    in_valid = 1'b0; rst_n = 1'b1; exp_ptr = 2'd0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL release_in_ready got %b exp %b", in_ready, 1'b1);
    end
  endtask

  task automatic test_explicit;
    logic [1:0]  chs [2];
    logic [15:0] ws  [2];
    exp_t e;
    chs[0] = 2'd2; ws[0] = 16'hA001;
    chs[1] = 2'd0; ws[1] = 16'hB002;
    rr_en = 1'b0; out_ready = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      S = chs[i]; in_data = ws[i]; in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL explicit_in_ready%0d got %b exp %b", i, in_ready, 1'b1);
      end
      sb.push_back('{ch: chs[i], data: ws[i]});
      tick;
      e = sb.pop_front();
      checks++;
      if (obs_data(e.ch) !== e.data || out_valid[e.ch] !== 1'b1) begin
        errors++; $display("FAIL explicit_route%0d got %h/%b exp %h/1", i, obs_data(e.ch), out_valid[e.ch], e.data);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0101 || out_data2 !== 16'hA001) begin
      errors++; $display("FAIL explicit_final got %b/%h exp 0101/a001", out_valid, out_data2);
    end
  endtask

  task automatic test_backpressure;
    exp_t e;
    rr_en = 1'b0; out_ready = 4'b0000; S = 2'd1;
    in_data = 16'h1111; in_valid = 1'b1;
    tick;
    in_data = 16'h2222;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_stall_ready got %b exp %b", in_ready, 1'b0);
    end
    tick;
    checks++;
    if (out_data1 !== 16'h1111 || out_valid[1] !== 1'b1) begin
      errors++; $display("FAIL bp_hold got %h/%b exp 1111/1", out_data1, out_valid[1]);
    end
    out_ready = 4'b0010;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready got %b exp %b", in_ready, 1'b1);
    end
    sb.push_back('{ch: 2'd1, data: 16'h2222});
    tick;
    e = sb.pop_front();
    checks++;
    if (obs_data(e.ch) !== e.data || out_valid[e.ch] !== 1'b1) begin
      errors++; $display("FAIL bp_replace got %h/%b exp %h/1", obs_data(e.ch), out_valid[e.ch], e.data);
    end
    in_valid = 1'b0; out_ready = 4'b0000;
  endtask

  task automatic test_rr_wrap;
    exp_t e;
    out_ready = 4'b1111; rr_en = 1'b1; S = 2'd3;
    tick;
    for (int i = 0; i < 5; i++) begin
      in_data = 16'h0010 + 16'(i); in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL rr_in_ready%0d got %b exp %b", i, in_ready, 1'b1);
      end
      sb.push_back('{ch: exp_ptr, data: in_data});
      exp_ptr = exp_ptr + 2'd1;
      tick;
      e = sb.pop_front();
      checks++;
      if (obs_data(e.ch) !== e.data || out_valid[e.ch] !== 1'b1) begin
        errors++; $display("FAIL rr_route%0d ch%0d got %h/%b exp %h/1", i, e.ch, obs_data(e.ch), out_valid[e.ch], e.data);
      end
      checks++;
      if (rr_ptr !== exp_ptr) begin
        errors++; $display("FAIL rr_ptr%0d got %0d exp %0d", i, rr_ptr, exp_ptr);
      end
    end
    in_valid = 1'b0;
    tick;
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++; $display("FAIL rr_drain got %b exp %b", out_valid, 4'b0000);
    end
  endtask

  task automatic test_independence;
    exp_t e;
    rr_en = 1'b0; out_ready = 4'b0000; S = 2'd3;
    in_data = 16'h3333; in_valid = 1'b1;
    tick;
    rr_en = 1'b1; out_ready = 4'b0111;
    for (int i = 0; i < 2; i++) begin
      in_data = 16'h4401 + 16'(i);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL ind_ready%0d got %b exp %b", i, in_ready, 1'b1);
      end
      sb.push_back('{ch: exp_ptr, data: in_data});
      exp_ptr = exp_ptr + 2'd1;
      tick;
      e = sb.pop_front();
      checks++;
      if (obs_data(e.ch) !== e.data || out_valid[e.ch] !== 1'b1 || rr_ptr !== exp_ptr) begin
        errors++; $display("FAIL ind_route%0d got %h/%b/%0d exp %h/1/%0d", i, obs_data(e.ch), out_valid[e.ch], rr_ptr, e.data, exp_ptr);
      end
    end
    in_data = 16'h4403;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL ind_stall_ready%0d got %b exp %b", i, in_ready, 1'b0);
      end
      tick;
      checks++;
      if (rr_ptr !== 2'd3 || out_data3 !== 16'h3333 || out_valid[3] !== 1'b1) begin
        errors++; $display("FAIL ind_stall%0d got %0d/%h/%b exp 3/3333/1", i, rr_ptr, out_data3, out_valid[3]);
      end
    end
    out_ready = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL ind_resume_ready%0d got %b exp %b", i, in_ready, 1'b1);
      end
      sb.push_back('{ch: exp_ptr, data: in_data});
      exp_ptr = exp_ptr + 2'd1;
      tick;
      e = sb.pop_front();
      checks++;
      if (obs_data(e.ch) !== e.data || out_valid[e.ch] !== 1'b1 || rr_ptr !== exp_ptr) begin
        errors++; $display("FAIL ind_resume%0d got %h/%b/%0d exp %h/1/%0d", i, obs_data(e.ch), out_valid[e.ch], rr_ptr, e.data, exp_ptr);
      end
      in_data = 16'h4404;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_mid_reset;
    out_ready = 4'b1111;
    tick;
    out_ready = 4'b0000; rr_en = 1'b1; in_data = 16'h5501; in_valid = 1'b1;
    exp_ptr = exp_ptr + 2'd1;
    tick;
    in_valid = 1'b0; out_ready = 4'b0010;
    tick;
    out_ready = 4'b0000; rr_en = 1'b0;
    S = 2'd0; in_data = 16'h5500; in_valid = 1'b1;
    tick;
    S = 2'd2; in_data = 16'h5502;
    tick;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0101 || rr_ptr !== exp_ptr || exp_ptr !== 2'd2) begin
      errors++; $display("FAIL mid_setup got %b/%0d exp 0101/%0d", out_valid, rr_ptr, exp_ptr);
    end
    rst_n = 1'b0; in_valid = 1'b1; in_data = 16'hFFFF;
    tick;
    checks++;
    if (out_valid !== 4'b0000 || rr_ptr !== 2'd0) begin
      errors++; $display("FAIL mid_reset got %b/%0d exp 0000/0", out_valid, rr_ptr);
    end
    checks++;
    if (out_data0 !== 16'h0 || out_data1 !== 16'h0 || out_data2 !== 16'h0 || out_data3 !== 16'h0) begin
      errors++; $display("FAIL mid_reset_data got %h %h %h %h exp 0000", out_data0, out_data1, out_data2, out_data3);
    end
    rst_n = 1'b1; in_valid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_explicit;
    test_backpressure;
    test_rr_wrap;
    test_independence;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_demux_1to4_16bit_reg
`default_nettype wire
